serial_word_rx: RTL and testbench

//  Serial-to-parallel receiver: the receiving end of the serial shift path.

---
 rtl/serial_word_rx_pkg.sv | 13 +
 rtl/serial_shift_core.sv | 59 +++++
 rtl/serial_word_rx.sv | 81 ++++++++
 tb/tb_serial_word_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_word_rx_pkg.sv
// Shared constants for the serial word receiver:
// shift direction codes and output-stage state encodings.
package serial_word_rx_pkg;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/serial_shift_core.sv
// Shift stage: collects qualified serial bits into a word.
// Direction is latched on the first bit of each word.
module serial_shift_core
   import serial_word_rx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ser_in,
   input  logic                     ser_valid,
   input  logic                     dir,
   input  logic                     sync_clr,
   output logic [WIDTH-1:0]         word,
   output logic                     word_done,
   output logic [$clog2(WIDTH):0]   bit_cnt
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_nxt;
   logic [CW-1:0]    cnt;
   logic             dir_q;
   logic             dir_eff;

   assign dir_eff = (cnt == '0) ? dir : dir_q;

   always_comb begin
      sr_nxt = sr;
      if (dir_eff == DIR_MSB_FIRST)
         sr_nxt = {sr[WIDTH-2:0], ser_in};
      else
         sr_nxt = {ser_in, sr[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr    <= '0;
         cnt   <= '0;
         dir_q <= DIR_LSB_FIRST;
      end else if (sync_clr) begin
         sr  <= '0;
         cnt <= '0;
      end else if (ser_valid) begin
         sr <= sr_nxt;
         if (cnt == '0)
            dir_q <= dir;
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   // Completed word is presented combinationally so the top can load it on the same edge
   assign word      = sr_nxt;
   assign word_done = ser_valid && !sync_clr && (cnt == LAST);
   assign bit_cnt   = cnt;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver top: output holding register,
// EMPTY/FULL handshake FSM and sticky overrun flag.
module serial_word_rx
   import serial_word_rx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ser_in,
   input  logic                     ser_valid,
   input  logic                     dir,
   input  logic                     sync_clr,
   output logic [WIDTH-1:0]         p_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     overrun,
   output logic [$clog2(WIDTH):0]   bit_cnt
);

   logic [WIDTH-1:0] word;
   logic             word_done;
   logic             load;
   logic             drop;
   out_state_t       state;
   out_state_t       state_nxt;

   serial_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .dir       (dir),
      .sync_clr  (sync_clr),
      .word      (word),
      .word_done (word_done),
      .bit_cnt   (bit_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= OUT_EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         OUT_EMPTY: if (word_done) state_nxt = OUT_FULL;
         OUT_FULL:  if (out_ready && !word_done) state_nxt = OUT_EMPTY;
         default:   state_nxt = OUT_EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state == OUT_FULL);
      load      = word_done && (!out_valid || out_ready);
      drop      = word_done && out_valid && !out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         p_out <= '0;
      else if (load)
         p_out <= word;
   end

   // sync_clr suppresses word_done, so clear and set never coincide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun <= 1'b0;
      else if (sync_clr)
         overrun <= 1'b0;
      else if (drop)
         overrun <= 1'b1;
   end

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (WIDTH=4):
// hand-computed words, handshake, overrun, clear and reset cases.
module tb_serial_word_rx;

   logic       clk;
   logic       rst_n;
   logic       ser_in;
   logic       ser_valid;
   logic       dir;
   logic       sync_clr;
   logic [3:0] p_out;
   logic       out_valid;
   logic       out_ready;
   logic       overrun;
   logic [2:0] bit_cnt;

   int errs;
   int checks;

   serial_word_rx #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .dir       (dir),
      .sync_clr  (sync_clr),
      .p_out     (p_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .bit_cnt   (bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b);
      ser_in    = b;
      ser_valid = 1'b1;
      tick();
      ser_valid = 1'b0;
   endtask

   task automatic send4(input logic [3:0] bits);
      for (int i = 0; i < 4; i++) send(bits[i]);
   endtask

   initial begin
      errs      = 0;
      checks    = 0;
      rst_n     = 1'b0;
      ser_in    = 1'b0;
      ser_valid = 1'b0;
      dir       = 1'b0;
      sync_clr  = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_p_out", p_out, 4'h0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      chk("rst_cnt", bit_cnt, 3'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: LSB-first 1,0,1,1
      dir = 1'b0;
      send(1); send(0); send(1);
      chk("t1_cnt3", bit_cnt, 3'd3);
      chk("t1_valid_pre", out_valid, 1'b0);
      send(1);
      chk("t1_p_out", p_out, 4'b1101);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_cnt_wrap", bit_cnt, 3'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t1_pop_valid", out_valid, 1'b0);
      chk("t1_stale", p_out, 4'b1101);

      // 2: MSB-first, dir toggled after first bit
      dir = 1'b1;
      send(1);
      dir = 1'b0;
      send(0); send(1); send(1);
      chk("t2_p_out", p_out, 4'b1011);
      chk("t2_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t2_pop", out_valid, 1'b0);

      // 3: overrun while holding 4'hD
      dir = 1'b0;
      send(1); send(0); send(1); send(1);
      chk("t3_first", p_out, 4'hD);
      send(0); send(0); send(1); send(0);
      chk("t3_hold", p_out, 4'hD);
      chk("t3_ovr", overrun, 1'b1);
      chk("t3_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t3_drain", out_valid, 1'b0);
      chk("t3_ovr_sticky", overrun, 1'b1);

      // 5: sync_clr with in-flight bit, then gapped word
      send(1); send(1);
      chk("t5_cnt2", bit_cnt, 3'd2);
      sync_clr  = 1'b1;
      ser_in    = 1'b1;
      ser_valid = 1'b1;
      tick();
      sync_clr  = 1'b0;
      ser_valid = 1'b0;
      chk("t5_clr_cnt", bit_cnt, 3'd0);
      chk("t5_clr_ovr", overrun, 1'b0);
      chk("t5_clr_valid", out_valid, 1'b0);
      send(0); tick();
      send(1); tick(); tick();
      send(1);
      send(0);
      chk("t5_p_out", p_out, 4'b0110);
      chk("t5_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 4: completion on the same edge as a pop
      send4(4'b1101);
      chk("t4_first", p_out, 4'hD);
      send(0); send(1); send(0);
      out_ready = 1'b1;
      send(1);
      out_ready = 1'b0;
      chk("t4_reload", p_out, 4'b1010);
      chk("t4_valid", out_valid, 1'b1);
      chk("t4_ovr", overrun, 1'b0);

      // 6: async reset mid-word with full holding reg and overrun set
      send4(4'b0111);
      chk("t6_ovr_set", overrun, 1'b1);
      chk("t6_hold", p_out, 4'b1010);
      send(1); send(1);
      rst_n = 1'b0;
      #2;
      chk("t6_p_out", p_out, 4'h0);
      chk("t6_valid", out_valid, 1'b0);
      chk("t6_ovr", overrun, 1'b0);
      chk("t6_cnt", bit_cnt, 3'd0);
      tick();
      rst_n = 1'b1;
      dir = 1'b1;
      send(0); send(0); send(1); send(1);
      chk("t6_clean", p_out, 4'b0011);
      chk("t6_clean_v", out_valid, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
